// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the single-cycle RV32 core.
// Handles stall, branch/jal/jalr redirect, trap entry, mret return and
// misaligned redirect targets (which divert into the trap vector).
// Optional return-address stack enabled by defining PC_GEN_RAS_EN.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [2:0]      pcmux,
  input  logic [XLEN-1:0] immb,
  input  logic [XLEN-1:0] immj,
  input  logic [XLEN-1:0] jt,
`ifdef PC_GEN_RAS_EN
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty,
`endif
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pc_valid,
  output logic [XLEN-1:0] mepc,
  output logic            misalign
);

  localparam logic [2:0] MUX_SEQ  = 3'b000;
  localparam logic [2:0] MUX_BR   = 3'b001;
  localparam logic [2:0] MUX_JAL  = 3'b010;
  localparam logic [2:0] MUX_JALR = 3'b011;
  localparam logic [2:0] MUX_TRAP = 3'b100;
  localparam logic [2:0] MUX_MRET = 3'b101;

  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(3'd4);
  localparam logic [XLEN-1:0] XLEN_ZRO = {XLEN{1'b0}};

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_r, state_s;
  logic [XLEN-1:0] pc_r, pc_s;
  logic [XLEN-1:0] mepc_r, mepc_s;
  logic            misalign_r, misalign_s;
  logic            pc_valid_r, pc_valid_s;
  logic [XLEN-1:0] pc_plus4_s;
  logic [XLEN-1:0] target_s;
  logic            redirect_s;
  logic            is_mret_s;

  assign pc_plus4_s = pc_r + PC_STEP;

  assign pc       = pc_r;
  assign pc_plus4 = pc_plus4_s;
  assign pc_valid = pc_valid_r;
  assign mepc     = mepc_r;
  assign misalign = misalign_r;

  // Decode the candidate next PC selected by pcmux (before stall/trap priority).
  always_comb begin
    target_s   = pc_r;
    redirect_s = 1'b0;
    is_mret_s  = 1'b0;
    case (pcmux)
      MUX_SEQ:  target_s = pc_plus4_s;
      MUX_BR: begin
        target_s   = pc_r + immb;
        redirect_s = 1'b1;
      end
      MUX_JAL: begin
        target_s   = pc_r + immj;
        redirect_s = 1'b1;
      end
      MUX_JALR: begin
        target_s   = {jt[XLEN-1:1], 1'b0};
        redirect_s = 1'b1;
      end
      MUX_MRET: begin
        target_s   = mepc_r;
        redirect_s = 1'b1;
        is_mret_s  = 1'b1;
      end
      default:  target_s = pc_r;
    endcase
  end

  // Next-state logic: BOOT holds the reset vector for one cycle, RUN applies
  // trap > stall > redirect/sequential priority with misalignment diversion.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    mepc_s     = mepc_r;
    misalign_s = 1'b0;
    pc_valid_s = pc_valid_r;
    case (state_r)
      ST_BOOT: begin
        state_s    = ST_RUN;
        pc_s       = RESET_VEC;
        pc_valid_s = 1'b1;
      end
      ST_RUN: begin
        pc_valid_s = 1'b1;
        if (pcmux == MUX_TRAP) begin
          pc_s   = TRAP_VEC;
          mepc_s = pc_r;
        end else if (stall) begin
          pc_s = pc_r;
        end else if (redirect_s && (target_s[1:0] != 2'b00)) begin
          // Misaligned target is never loaded; enter the trap vector instead.
          // mret keeps the existing mepc so the return address is not lost.
          pc_s       = TRAP_VEC;
          misalign_s = 1'b1;
          if (is_mret_s) begin
            mepc_s = mepc_r;
          end else begin
            mepc_s = pc_r;
          end
        end else begin
          pc_s = target_s;
        end
      end
      default: begin
        state_s    = ST_BOOT;
        pc_s       = RESET_VEC;
        mepc_s     = XLEN_ZRO;
        pc_valid_s = 1'b0;
      end
    endcase
  end

  // State and PC registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_BOOT;
      pc_r       <= RESET_VEC;
      mepc_r     <= XLEN_ZRO;
      misalign_r <= 1'b0;
      pc_valid_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      mepc_r     <= mepc_s;
      misalign_r <= misalign_s;
      pc_valid_r <= pc_valid_s;
    end
  end

`ifdef PC_GEN_RAS_EN
  localparam int              PW       = $clog2(RAS_DEPTH);
  localparam logic [PW:0]     RAS_FULL = (PW+1)'(RAS_DEPTH);
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1'b1);
  localparam logic [PW:0]     CNT_ONE  = (PW+1)'(1'b1);
  localparam logic [PW:0]     CNT_ZRO  = {(PW+1){1'b0}};

  logic [XLEN-1:0] ras_mem_r [RAS_DEPTH];
  logic [PW-1:0]   ras_wp_r, ras_wp_s;
  logic [PW:0]     ras_cnt_r, ras_cnt_s;
  logic [PW-1:0]   ras_top_idx_s;
  logic [PW-1:0]   ras_widx_s;
  logic            ras_we_s;
  logic            ras_go_s;
  logic            ras_do_push_s;
  logic            ras_do_pop_s;

  assign ras_top_idx_s = ras_wp_r - PTR_ONE;
  assign ras_go_s      = (state_r == ST_RUN) && !stall && (pcmux != MUX_TRAP);
  assign ras_do_push_s = ras_go_s && ras_push;
  assign ras_do_pop_s  = ras_go_s && ras_pop && (ras_cnt_r != CNT_ZRO);
  assign ras_empty     = (ras_cnt_r == CNT_ZRO);
  assign ras_top       = ras_empty ? XLEN_ZRO : ras_mem_r[ras_top_idx_s];

  // Stack pointer/count update; a full stack overwrites its oldest entry
  // because the write pointer simply wraps.
  always_comb begin
    ras_wp_s   = ras_wp_r;
    ras_cnt_s  = ras_cnt_r;
    ras_we_s   = 1'b0;
    ras_widx_s = ras_wp_r;
    if (ras_do_push_s && ras_do_pop_s) begin
      ras_we_s   = 1'b1;
      ras_widx_s = ras_top_idx_s;
    end else if (ras_do_push_s) begin
      ras_we_s   = 1'b1;
      ras_widx_s = ras_wp_r;
      ras_wp_s   = ras_wp_r + PTR_ONE;
      if (ras_cnt_r == RAS_FULL) begin
        ras_cnt_s = ras_cnt_r;
      end else begin
        ras_cnt_s = ras_cnt_r + CNT_ONE;
      end
    end else if (ras_do_pop_s) begin
      ras_wp_s  = ras_wp_r - PTR_ONE;
      ras_cnt_s = ras_cnt_r - CNT_ONE;
    end else begin
      ras_we_s = 1'b0;
    end
  end

  // Return-address stack storage and pointers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ras_wp_r  <= {PW{1'b0}};
      ras_cnt_r <= CNT_ZRO;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_r[i] <= XLEN_ZRO;
      end
    end else begin
      ras_wp_r  <= ras_wp_s;
      ras_cnt_r <= ras_cnt_s;
      if (ras_we_s) begin
        ras_mem_r[ras_widx_s] <= pc_plus4_s;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: the driver pushes the expected post-edge
// state for every cycle it drives; a monitor on the falling edge pops and
// compares. Define PC_GEN_RAS_EN to also exercise the return-address stack.
module tb_pc_gen;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic [31:0] mepc;
    logic        mis;
    logic [31:0] top;
    logic        empty;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  pcmux = 3'b000;
  logic [31:0] immb = 32'h0;
  logic [31:0] immj = 32'h0;
  logic [31:0] jt = 32'h0;
  logic        ras_push = 1'b0;
  logic        ras_pop = 1'b0;
  logic [31:0] ras_top;
  logic        ras_empty;
  logic [31:0] pc, pc_plus4, mepc;
  logic        pc_valid, misalign;

  logic [31:0] exp_top = 32'h0;
  logic        exp_empty = 1'b1;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .pcmux    (pcmux),
    .immb     (immb),
    .immj     (immj),
    .jt       (jt),
`ifdef PC_GEN_RAS_EN
    .ras_push (ras_push),
    .ras_pop  (ras_pop),
    .ras_top  (ras_top),
    .ras_empty(ras_empty),
`endif
    .pc       (pc),
    .pc_plus4 (pc_plus4),
    .pc_valid (pc_valid),
    .mepc     (mepc),
    .misalign (misalign)
  );

`ifndef PC_GEN_RAS_EN
  assign ras_top   = 32'h0;
  assign ras_empty = 1'b1;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // One clock: inputs already set by caller; record expected post-edge state.
  task automatic step(input logic [31:0] e_pc, input logic e_valid,
                      input logic [31:0] e_mepc, input logic e_mis);
    exp_t e;
    @(posedge clk);
    #1;
    e.pc    = e_pc;
    e.valid = e_valid;
    e.mepc  = e_mepc;
    e.mis   = e_mis;
    e.top   = exp_top;
    e.empty = exp_empty;
    sb_q.push_back(e);
  endtask

  // Monitor: compare the DUT against each pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("pc",       pc,                e.pc);
      chk("pc_plus4", pc_plus4,          e.pc + 32'd4);
      chk("pc_valid", {31'd0, pc_valid}, {31'd0, e.valid});
      chk("mepc",     mepc,              e.mepc);
      chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
`ifdef PC_GEN_RAS_EN
      chk("ras_top",   ras_top,            e.top);
      chk("ras_empty", {31'd0, ras_empty}, {31'd0, e.empty});
`endif
    end
  end

  initial begin
    // 1. reset then sequential fetch
    reset = 1'b0;
    step(32'h0, 1'b0, 32'h0, 1'b0);
    step(32'h0, 1'b0, 32'h0, 1'b0);
    reset = 1'b1; pcmux = 3'b000;
    step(32'h0, 1'b1, 32'h0, 1'b0);
    step(32'h4, 1'b1, 32'h0, 1'b0);
    step(32'h8, 1'b1, 32'h0, 1'b0);
    step(32'hC, 1'b1, 32'h0, 1'b0);
    // 2. branch backwards, jal forwards
    pcmux = 3'b001; immb = 32'hFFFF_FFFC;
    step(32'h8, 1'b1, 32'h0, 1'b0);
    immb = 32'hFFFF_FFF8;
    step(32'h0, 1'b1, 32'h0, 1'b0);
    pcmux = 3'b010; immj = 32'h20;
    step(32'h20, 1'b1, 32'h0, 1'b0);
    // 3. jalr with bit0 cleared, then misaligned jalr
    pcmux = 3'b011; jt = 32'h41;
    step(32'h40, 1'b1, 32'h0, 1'b0);
    pcmux = 3'b010; immj = 32'hFFFF_FFE0;
    step(32'h20, 1'b1, 32'h0, 1'b0);
    pcmux = 3'b011; jt = 32'h42;
    step(32'h100, 1'b1, 32'h20, 1'b1);
    pcmux = 3'b000;
    step(32'h104, 1'b1, 32'h20, 1'b0);
    // 4. stall holds, stall does not block trap, mret returns
    pcmux = 3'b011; jt = 32'h10;
    step(32'h10, 1'b1, 32'h20, 1'b0);
    stall = 1'b1; pcmux = 3'b001; immb = 32'h8;
    step(32'h10, 1'b1, 32'h20, 1'b0);
    pcmux = 3'b100;
    step(32'h100, 1'b1, 32'h10, 1'b0);
    stall = 1'b0; pcmux = 3'b101;
    step(32'h10, 1'b1, 32'h10, 1'b0);
    // misaligned branch, hold codes, misaligned jal
    pcmux = 3'b001; immb = 32'h2;
    step(32'h100, 1'b1, 32'h10, 1'b1);
    pcmux = 3'b110;
    step(32'h100, 1'b1, 32'h10, 1'b0);
    pcmux = 3'b111;
    step(32'h100, 1'b1, 32'h10, 1'b0);
    pcmux = 3'b010; immj = 32'h6;
    step(32'h100, 1'b1, 32'h100, 1'b1);
    // 5. wrap-around, reset overriding trap
    pcmux = 3'b011; jt = 32'hFFFF_FFFD;
    step(32'hFFFF_FFFC, 1'b1, 32'h100, 1'b0);
    pcmux = 3'b000;
    step(32'h0, 1'b1, 32'h100, 1'b0);
    pcmux = 3'b100; reset = 1'b0;
    step(32'h0, 1'b0, 32'h0, 1'b0);
    reset = 1'b1; pcmux = 3'b000;
    step(32'h0, 1'b1, 32'h0, 1'b0);
`ifdef PC_GEN_RAS_EN
    // 6. five pushes into a 4-deep stack, then drain
    ras_push = 1'b1;
    exp_empty = 1'b0;
    exp_top = 32'h4;  step(32'h4,  1'b1, 32'h0, 1'b0);
    exp_top = 32'h8;  step(32'h8,  1'b1, 32'h0, 1'b0);
    exp_top = 32'hC;  step(32'hC,  1'b1, 32'h0, 1'b0);
    exp_top = 32'h10; step(32'h10, 1'b1, 32'h0, 1'b0);
    exp_top = 32'h14; step(32'h14, 1'b1, 32'h0, 1'b0);
    ras_push = 1'b0; stall = 1'b1;
    ras_pop = 1'b1;
    step(32'h14, 1'b1, 32'h0, 1'b0);
    stall = 1'b0;
    exp_top = 32'h10; step(32'h18, 1'b1, 32'h0, 1'b0);
    exp_top = 32'hC;  step(32'h1C, 1'b1, 32'h0, 1'b0);
    exp_top = 32'h8;  step(32'h20, 1'b1, 32'h0, 1'b0);
    exp_top = 32'h0; exp_empty = 1'b1;
    step(32'h24, 1'b1, 32'h0, 1'b0);
    step(32'h28, 1'b1, 32'h0, 1'b0);
    ras_pop = 1'b0;
`endif
    // drain the scoreboard with a bounded wait
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
